// File: rtl/pipe_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_unit_if
// Purpose  : Groups the signals between the ID-stage decode logic and the
//            pipeline hazard/forwarding controller.
//   master : datapath side. Drives the ID decode fields and receives the
//            pipeline controls.
//   slave  : hazard unit side.
//   Fields : id_valid, id_rs/id_rt, id_use_rs/id_use_rt, id_rd,
//            id_reg_write, id_mem_read, branch_taken
//            -> pc_load, ifid_ld, ifid_flush, idex_bubble,
//               forward_A/B, stall_cnt, flush_cnt, hazard_state
//   Macro  : HAZARD_BRANCH_ID_FWD_EN adds id_is_branch, fwd_id_A and
//            fwd_id_B for forwarding into the ID-stage branch comparator.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_unit_if #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              branch_taken;

    logic              pc_load;
    logic              ifid_ld;
    logic              ifid_flush;
    logic              idex_bubble;
    logic [SEL_W-1:0]  forward_A;
    logic [SEL_W-1:0]  forward_B;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic [1:0]        hazard_state;

`ifdef HAZARD_BRANCH_ID_FWD_EN
    logic              id_is_branch;
    logic [SEL_W-1:0]  fwd_id_A;
    logic [SEL_W-1:0]  fwd_id_B;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
               id_reg_write, id_mem_read, branch_taken, id_is_branch,
        input  pc_load, ifid_ld, ifid_flush, idex_bubble, forward_A,
               forward_B, stall_cnt, flush_cnt, hazard_state,
               fwd_id_A, fwd_id_B
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
               id_reg_write, id_mem_read, branch_taken, id_is_branch,
        output pc_load, ifid_ld, ifid_flush, idex_bubble, forward_A,
               forward_B, stall_cnt, flush_cnt, hazard_state,
               fwd_id_A, fwd_id_B
    );
`else
    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
               id_reg_write, id_mem_read, branch_taken,
        input  pc_load, ifid_ld, ifid_flush, idex_bubble, forward_A,
               forward_B, stall_cnt, flush_cnt, hazard_state
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
               id_reg_write, id_mem_read, branch_taken,
        output pc_load, ifid_ld, ifid_flush, idex_bubble, forward_A,
               forward_B, stall_cnt, flush_cnt, hazard_state
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_unit
// Purpose  : Hazard/forwarding controller for a pipelined MIPS datapath.
//            It keeps a shadow pipeline of in-flight destinations (slot 0 =
//            EX, slot k = k stages after EX). From that it drives the EX
//            forwarding selects, the load-use stall, the IF/ID flush and
//            saturating stall/flush counters.
// Ports    : clock        - rising-edge clock
//            reset        - asynchronous, active-low reset
//            hz (slave)   - ID decode fields in, pipeline controls out
//                           (see pipe_hazard_unit_if)
// Macro    : HAZARD_BRANCH_ID_FWD_EN - forwarding into the ID-stage branch
//            comparator (fwd_id_A/B), with stalls for branch operands that
//            are not ready yet.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    pipe_hazard_unit_if.slave hz
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // Shadow pipeline: per-slot valid/write/load flags and destination.
    // Only slot 0 (EX) keeps its source fields, because it is the consumer
    // whose operands get forwarded.
    logic [FWD_STAGES:0] r_vld;
    logic [FWD_STAGES:0] r_wr;
    logic [FWD_STAGES:0] r_ld;
    logic [REG_AW-1:0]   r_rd [0:FWD_STAGES];
    logic [REG_AW-1:0]   r_rs;
    logic [REG_AW-1:0]   r_rt;
    logic                r_use_rs;
    logic                r_use_rt;

    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;
    hz_state_t           r_state;
    hz_state_t           w_state_nxt;

    logic                w_ld_hit_rs;
    logic                w_ld_hit_rt;
    logic                w_stall;
    logic                w_flush;
    logic [SEL_W-1:0]    w_fwd_a;
    logic [SEL_W-1:0]    w_fwd_b;

    // EX forwarding: the loop walks from the oldest slot to the youngest,
    // so the last match to be written is the youngest producer.
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (r_use_rs && (r_rs != '0) && r_vld[k] && r_wr[k] && (r_rd[k] == r_rs))
                w_fwd_a = SEL_W'(k);
            if (r_use_rt && (r_rt != '0) && r_vld[k] && r_wr[k] && (r_rd[k] == r_rt))
                w_fwd_b = SEL_W'(k);
        end
    end

    // Load-use detection. Only the youngest producer of each ID source
    // counts, so a newer ALU write to the same register hides an older
    // load. A producer at slot j is ready for a consumer entering EX next
    // cycle once j >= LOAD_LAT.
    always_comb begin
        w_ld_hit_rs = 1'b0;
        w_ld_hit_rt = 1'b0;
        for (int j = FWD_STAGES; j >= 0; j--) begin
            if (hz.id_use_rs && (hz.id_rs != '0) && r_vld[j] && r_wr[j] && (r_rd[j] == hz.id_rs))
                w_ld_hit_rs = r_ld[j] && (j < LOAD_LAT);
            if (hz.id_use_rt && (hz.id_rt != '0) && r_vld[j] && r_wr[j] && (r_rd[j] == hz.id_rt))
                w_ld_hit_rt = r_ld[j] && (j < LOAD_LAT);
        end
    end

`ifdef HAZARD_BRANCH_ID_FWD_EN
    logic             w_br_hz;
    logic [SEL_W-1:0] w_fwd_id_a;
    logic [SEL_W-1:0] w_fwd_id_b;

    // Branch operands are compared in ID. The comparator may take data
    // only from slots that already hold the result. A producer still in
    // EX, or a load whose data has not returned, has to be waited out.
    always_comb begin
        w_fwd_id_a = '0;
        w_fwd_id_b = '0;
        w_br_hz    = 1'b0;
        if (hz.id_use_rs && (hz.id_rs != '0) && r_vld[0] && r_wr[0] && (r_rd[0] == hz.id_rs))
            w_br_hz = 1'b1;
        if (hz.id_use_rt && (hz.id_rt != '0) && r_vld[0] && r_wr[0] && (r_rd[0] == hz.id_rt))
            w_br_hz = 1'b1;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (hz.id_use_rs && (hz.id_rs != '0) && r_vld[k] && r_wr[k] && (r_rd[k] == hz.id_rs)) begin
                if (!r_ld[k] || (k >= 1 + LOAD_LAT))
                    w_fwd_id_a = SEL_W'(k);
                else
                    w_br_hz = 1'b1;
            end
            if (hz.id_use_rt && (hz.id_rt != '0) && r_vld[k] && r_wr[k] && (r_rd[k] == hz.id_rt)) begin
                if (!r_ld[k] || (k >= 1 + LOAD_LAT))
                    w_fwd_id_b = SEL_W'(k);
                else
                    w_br_hz = 1'b1;
            end
        end
    end

    assign w_stall     = hz.id_valid && (w_ld_hit_rs || w_ld_hit_rt || (hz.id_is_branch && w_br_hz));
    assign hz.fwd_id_A = w_fwd_id_a;
    assign hz.fwd_id_B = w_fwd_id_b;
`else
    assign w_stall     = hz.id_valid && (w_ld_hit_rs || w_ld_hit_rt);
`endif

    // A stall wins over a redirect. The branch stays in ID and is
    // evaluated again next cycle.
    assign w_flush        = hz.branch_taken && !w_stall;

    assign hz.pc_load     = !w_stall;
    assign hz.ifid_ld     = !w_stall;
    assign hz.idex_bubble = w_stall;
    assign hz.ifid_flush  = w_flush;
    assign hz.forward_A   = w_fwd_a;
    assign hz.forward_B   = w_fwd_b;
    assign hz.stall_cnt   = r_stall_cnt;
    assign hz.flush_cnt   = r_flush_cnt;
    assign hz.hazard_state = r_state;

    // Shadow pipeline advance. While stalled, a bubble enters EX.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld    <= '0;
            r_wr     <= '0;
            r_ld     <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_use_rs <= 1'b0;
            r_use_rt <= 1'b0;
            for (int k = 0; k <= FWD_STAGES; k++)
                r_rd[k] <= '0;
        end else begin
            for (int k = FWD_STAGES; k >= 1; k--) begin
                r_vld[k] <= r_vld[k-1];
                r_wr[k]  <= r_wr[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_rd[k]  <= r_rd[k-1];
            end
            if (w_stall) begin
                r_vld[0] <= 1'b0;
                r_wr[0]  <= 1'b0;
                r_ld[0]  <= 1'b0;
                r_rd[0]  <= '0;
                r_rs     <= '0;
                r_rt     <= '0;
                r_use_rs <= 1'b0;
                r_use_rt <= 1'b0;
            end else begin
                r_vld[0] <= hz.id_valid;
                r_wr[0]  <= hz.id_reg_write;
                r_ld[0]  <= hz.id_mem_read;
                r_rd[0]  <= hz.id_rd;
                r_rs     <= hz.id_rs;
                r_rt     <= hz.id_rt;
                r_use_rs <= hz.id_use_rs;
                r_use_rt <= hz.id_use_rt;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_cnt_max))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_flush && (r_flush_cnt != c_cnt_max))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    // hazard_state records last cycle's outcome.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_stall)
            w_state_nxt = ST_STALL;
        else if (w_flush)
            w_state_nxt = ST_FLUSH;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard/forwarding controller for the pipelined MIPS datapath.
- Tracks in-flight destination registers in its own shadow pipeline and drives forwarding selects, load-use stall, and IF/ID flush.
- Generalises to a configurable forwarding depth and load latency.
- Adds saturating stall/flush performance counters.
- Sits beside the datapath: takes ID-stage decode fields and drives PC/IF-ID/ID-EX controls.

Parameters:
- REG_AW, 5, register-address width.
- FWD_STAGES, 2, number of post-EX stages that can forward (slot 1 = EX/MEM … slot FWD_STAGES = last, i.e. WB).
- LOAD_LAT, 1, number of cycles after EX before load data is forwardable; range 1..FWD_STAGES-1.
- CNT_W, 16, performance counter width.
- SEL_W, $clog2(FWD_STAGES+1), forward-select width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt  in  REG_AW each  ID source registers
- id_use_rs, id_use_rt  in  1 each  source actually read
- id_rd  in  REG_AW  resolved destination register (Rt/Rd/31)
- id_reg_write, id_mem_read  in  1 each  ID control bits
- branch_taken  in  1  ID-stage branch/jump redirect
- pc_load  out  1  PC write enable
- ifid_ld  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID flush
- idex_bubble  out  1  zero ID/EX controls this cycle
- forward_A, forward_B  out  SEL_W each  EX operand select: 0 = register file, k = slot k
- stall_cnt, flush_cnt  out  CNT_W each  performance counters
- hazard_state  out  2  IDLE=0, STALL=1, FLUSH=2

Behaviour:
- Shadow pipeline: slots 0..FWD_STAGES.
  - Slot 0 = EX; holds {valid, wr, ld, rd, rs, rt, use_rs, use_rt}.
  - Slots ≥1 hold {valid, wr, ld, rd}.
- Every clock, slots k → k+1 and the last slot is dropped.
- Slot 0 load:
  - ID fields, with valid = id_valid, when not stalling.
  - All-zero bubble when stalling.
- Producer match: slot valid & wr & rd == src & src != 0 & use flag set.
- Forward select (combinational from state):
  - Smallest k in 1..FWD_STAGES matching slot-0 rs (A) / rt (B); else 0.
  - Youngest producer wins.
- Stall (combinational):
  - Asserted when id_valid and, for either used ID source, the youngest matching producer among slots 0..FWD_STAGES-1 is at index j < LOAD_LAT with ld = 1.
  - A younger non-load writer to the same register masks an older load.
- Stall outputs:
  - pc_load = ifid_ld = 0, idex_bubble = 1, ifid_flush = 0.
  - Stall overrides branch_taken; the branch is re-evaluated next cycle.
- Flush: ifid_flush = branch_taken & ~stall.
- Otherwise: pc_load = ifid_ld = 1, idex_bubble = 0.
- hazard_state: registered copy of the cycle's outcome (STALL > FLUSH > IDLE), one-cycle latency.
- Counters:
  - stall_cnt increments on each stall cycle; flush_cnt on each flush cycle.
  - Both saturate at all-ones (no wrap).
- Register 0 is never a producer: no forward, no stall.
- Reset (asynchronous, active-low) values:
  - All slots invalid; counters 0; hazard_state IDLE.
  - Combinational outputs settle to pc_load = 1, ifid_ld = 1, flush = 0, bubble = 0, forwards 0.
  - Assertion mid-stall clears the stall immediately.
- Back-to-back loads into the same register: only the youngest is considered.

Optional Feature:
- Macro: HAZARD_BRANCH_ID_FWD_EN.
- When defined, adds outputs fwd_id_A, fwd_id_B (SEL_W) to forward into the ID-stage comparator:
  - Select is the smallest matching k in 1..FWD_STAGES, considering only slots whose data is ready (non-load, or ld with k ≥ 1+LOAD_LAT).
  - Stall is also asserted when branch_taken-qualified input id_is_branch = 1 and any used ID source matches slot 0 (any writer), or matches a load not yet ready.
- When undefined: the ports and logic are absent, and the branch comparator reads only the register file.

Test Plan:
- Reset held low 3 cycles, then released → pc_load = 1, ifid_ld = 1, forwards 0, counters 0, hazard_state 0.
- add $3 then sub $4,$3,$5 → next cycle forward_A = 1; one cycle later for a consumer two behind → forward_A = 2.
- lw $2 then add $6,$2,$7 (LOAD_LAT = 1):
  - One stall cycle: pc_load = 0, idex_bubble = 1, stall_cnt = 1.
  - Following cycle forward_A = 2.
- branch_taken = 1 with no hazard → ifid_flush = 1, flush_cnt = 1; branch_taken with a simultaneous load-use stall → ifid_flush = 0, stall = 1.
- Destination $0 written by a load, consumer reads $0 → no stall, forward 0.
- CNT_W = 4, 20 consecutive stalls → stall_cnt holds 15; asynchronous reset mid-stall → stall drops without a clock edge, stall_cnt = 0.
